// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared types and width helpers for the reset sequencer
// Contents:
//   seq_state_t : sequencer FSM encoding (3 is unused and recovers to WAIT_LOCK)
//   cnt_w()     : counter width for a count range of n values, never below 1 bit
package rst_seq_pkg;

  localparam int SEQ_STATE_W = 2;

  typedef enum logic [SEQ_STATE_W-1:0] {
    WAIT_LOCK = 2'd0,
    RELEASE   = 2'd1,
    RUN       = 2'd2
  } seq_state_t;

  // Width needed to hold values 0..n-1; a single-value range still gets one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// rtl/clk_en_div.sv - per-domain programmable clock-enable divider
// Ports:
//   sys_clk : clock
//   sys_rst : synchronous active-high reset
//   run     : domain running; low holds the counter at 0 and clk_en at 0
//   div     : divide ratio minus 1, captured while held and at every wrap
//   clk_en  : registered one-cycle enable each time the counter wraps
module clk_en_div #(
  parameter int DIV_W = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             clk_en
);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_q;

  // div_q is the ratio of the period in progress, so a mid-period change of
  // div only shows up after the next wrap.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      div_cnt <= '0;
      div_q   <= '0;
      clk_en  <= 1'b0;
    end else if (!run) begin
      div_cnt <= '0;
      div_q   <= div;
      clk_en  <= 1'b0;
    end else if (div_cnt == div_q) begin
      div_cnt <= '0;
      div_q   <= div;
      clk_en  <= 1'b1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
      clk_en  <= 1'b0;
    end
  end

endmodule

// File: rtl/rst_seq_gen.sv
// rtl/rst_seq_gen.sv - multi-domain reset sequencer with divided clock enables
// Ports:
//   sys_clk    : sole clock
//   sys_rst    : synchronous active-high reset, highest priority
//   pll_lock   : PLL lock, already synchronous to sys_clk
//   ch_rst_req : per-domain software reset request (level, honoured in RUN)
//   ch_div     : per-domain divide ratio minus 1, field i at [i*DIV_W +: DIV_W]
//   rst_out_n  : per-domain active-low reset
//   clk_en     : per-domain divided clock enable
//   seq_done   : all domains released (RUN)
//   seq_state  : 0 WAIT_LOCK, 1 RELEASE, 2 RUN
module rst_seq_gen
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 20,
  parameter int LOCK_WAIT = 16,
  parameter int STAGE_GAP = 4,
  parameter int SOFT_LEN  = 8,
  parameter int DIV_W     = 4
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    pll_lock,
  input  logic [NUM_CH-1:0]       ch_rst_req,
  input  logic [NUM_CH*DIV_W-1:0] ch_div,
  output logic [NUM_CH-1:0]       rst_out_n,
  output logic [NUM_CH-1:0]       clk_en,
  output logic                    seq_done,
  output logic [1:0]              seq_state
);

  localparam int GAP_W  = cnt_w(STAGE_GAP);
  localparam int SOFT_W = cnt_w(SOFT_LEN);
  localparam int IDX_W  = cnt_w(NUM_CH);

  seq_state_t        state_q, state_d;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [IDX_W-1:0]  ch_idx_q, ch_idx_d;
  logic [SOFT_W-1:0] soft_cnt_q [NUM_CH];
  logic [SOFT_W-1:0] soft_cnt_d [NUM_CH];
  logic [NUM_CH-1:0] rst_n_d;
  logic              seq_done_d;
  logic              clear_all;

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    ch_idx_d   = ch_idx_q;
    soft_cnt_d = soft_cnt_q;
    rst_n_d    = rst_out_n;
    seq_done_d = seq_done;
    clear_all  = 1'b0;

    case (state_q)
      WAIT_LOCK: begin
        if (!pll_lock) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q == CNT_W'(LOCK_WAIT - 1)) begin
          lock_cnt_d = '0;
          gap_cnt_d  = '0;
          rst_n_d[0] = 1'b1;
          if (NUM_CH == 1) begin
            state_d    = RUN;
            seq_done_d = 1'b1;
            ch_idx_d   = '0;
          end else begin
            state_d  = RELEASE;
            ch_idx_d = IDX_W'(1);
          end
        end else begin
          lock_cnt_d = lock_cnt_q + CNT_W'(1);
        end
      end

      RELEASE: begin
        if (!pll_lock) begin
          clear_all = 1'b1;
        end else if (gap_cnt_q == GAP_W'(STAGE_GAP - 1)) begin
          rst_n_d[ch_idx_q] = 1'b1;
          gap_cnt_d         = '0;
          if (ch_idx_q == IDX_W'(NUM_CH - 1)) begin
            state_d    = RUN;
            seq_done_d = 1'b1;
          end else begin
            ch_idx_d = ch_idx_q + IDX_W'(1);
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      RUN: begin
        if (!pll_lock) begin
          clear_all = 1'b1;
        end else begin
          // A request (re)loads the pulse length, so a held or repeated
          // request stretches the pulse.
          for (int i = 0; i < NUM_CH; i++) begin
            if (ch_rst_req[i]) begin
              rst_n_d[i]    = 1'b0;
              soft_cnt_d[i] = SOFT_W'(SOFT_LEN - 1);
            end else if (soft_cnt_q[i] != '0) begin
              soft_cnt_d[i] = soft_cnt_q[i] - SOFT_W'(1);
            end else begin
              rst_n_d[i] = 1'b1;
            end
          end
        end
      end

      default: clear_all = 1'b1;
    endcase

    if (clear_all) begin
      state_d    = WAIT_LOCK;
      lock_cnt_d = '0;
      gap_cnt_d  = '0;
      ch_idx_d   = '0;
      rst_n_d    = '0;
      seq_done_d = 1'b0;
      for (int i = 0; i < NUM_CH; i++) soft_cnt_d[i] = '0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= WAIT_LOCK;
      lock_cnt_q <= '0;
      gap_cnt_q  <= '0;
      ch_idx_q   <= '0;
      rst_out_n  <= '0;
      seq_done   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) soft_cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      ch_idx_q   <= ch_idx_d;
      rst_out_n  <= rst_n_d;
      seq_done   <= seq_done_d;
      for (int i = 0; i < NUM_CH; i++) soft_cnt_q[i] <= soft_cnt_d[i];
    end
  end

  assign seq_state = state_q;

  // The divider runs only while the domain is released now and stays
  // released next cycle: the release edge itself does not count, and the
  // enable drops on the same edge as the reset does.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_div
    clk_en_div #(.DIV_W(DIV_W)) u_div (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .run     (rst_out_n[i] & rst_n_d[i]),
      .div     (ch_div[i*DIV_W +: DIV_W]),
      .clk_en  (clk_en[i])
    );
  end

endmodule
